// File: rtl/bmem_dp_clr.sv
// Dual-port block memory (A: read/write, B: read-only) with selectable
// read-during-write behaviour, optional output register and a built-in clear sequencer.
module bmem_dp_clr #(
  parameter int              DW      = 47,
  parameter int              AW      = 9,
  parameter int              OUT_REG = 0,
  parameter int              WR_MODE = 0,
  parameter logic [DW-1:0]   CLR_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] dout_a,
  output logic          vld_a,
  input  logic          re_b,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] dout_b,
  output logic          vld_b,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t        state;
  logic [AW:0]   cnt;
  logic [DW-1:0] mem [DEPTH];

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rdata_a, rdata_b;

  // The clear sequencer owns the single write port; user writes only land in IDLE.
  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr_a;
    wr_data = din_a;
    rdata_a = mem[addr_a];
    rdata_b = mem[addr_b];
    if (!rst) begin
      if (state == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = cnt[AW-1:0];
        wr_data = CLR_VAL;
      end else if (state == IDLE && we_a) begin
        wr_en   = 1'b1;
      end
    end
    if (WR_MODE != 0 && wr_en) begin
      if (wr_addr == addr_a) rdata_a = wr_data;
      if (wr_addr == addr_b) rdata_b = wr_data;
    end
  end

  // NOTE: the array has no reset; contents survive rst so a reset mid-clear leaves it partial.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // First read stage: dout holds while re is low, only the valid flag drops.
  logic [DW-1:0] q_a, q_b;
  logic          v_a, v_b;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
      v_a <= 1'b0;
      v_b <= 1'b0;
    end else begin
      v_a <= re_a;
      v_b <= re_b;
      if (re_a) q_a <= rdata_a;
      if (re_b) q_b <= rdata_b;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_a <= '0;
          dout_b <= '0;
          vld_a  <= 1'b0;
          vld_b  <= 1'b0;
        end else begin
          vld_a <= v_a;
          vld_b <= v_b;
          if (v_a) dout_a <= q_a;
          if (v_b) dout_b <= q_b;
        end
      end
    end else begin : g_no_out_reg
      assign dout_a = q_a;
      assign dout_b = q_b;
      assign vld_a  = v_a;
      assign vld_b  = v_b;
    end
  endgenerate

  // Clear sequencer: busy spans exactly DEPTH cycles, done pulses once afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_start) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + (AW+1)'(1);
          if (cnt == (AW+1)'(DEPTH - 1)) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        DONE: begin
          clr_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bmem_dp_clr.md
Name: bmem_dp_clr

Overview:
Parametrised dual-port block memory for keypoint/candidate record storage in the SIFT pipeline (default record: row 9 + col 10 + dist 14 + dist2 14 = 47 bits). Port A reads and writes; port B is read-only. It adds a selectable read-during-write mode, an optional output register, per-port read-valid tracking, and a built-in clear sequencer. The sequencer re-initialises every entry between frames without host writes.

Parameters:
DW, 47, data word width in bits
AW, 9, address width; DEPTH = 2**AW entries
OUT_REG, 0, 0: read latency 1; 1: extra output register, read latency 2
WR_MODE, 0, 0: read-first (old data on same-address collision); 1: write-first (new data forwarded)
CLR_VAL, {DW{1'b0}}, word written to every entry by the clear sequencer

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
re_a  in  1  port A read enable
we_a  in  1  port A write enable
addr_a  in  AW  port A address (read and write)
din_a  in  DW  port A write data
dout_a  out  DW  port A read data
vld_a  out  1  dout_a holds data for a re_a issued LAT cycles earlier
re_b  in  1  port B read enable
addr_b  in  AW  port B read address
dout_b  out  DW  port B read data
vld_b  out  1  dout_b valid
clr_start  in  1  pulse: start a full-memory clear
clr_busy  out  1  clear sequencer active
clr_done  out  1  one-cycle pulse after the last clear write

Behaviour:
- LAT = 1 + OUT_REG. A read issued at cycle t appears on dout_x and vld_x at t+LAT.
- Reset values: dout_a = dout_b = 0; vld_a = vld_b = 0; clr_busy = 0; clr_done = 0; clear FSM in IDLE; clear counter = 0. Memory contents are not reset.
- dout_x holds its last value when re_x = 0. Only vld_x drops.
- Port A write: if we_a = 1 and the FSM is IDLE, mem[addr_a] <= din_a at the clock edge.
- re_a and we_a may both be 1 on the same address. WR_MODE 0 returns the old word; WR_MODE 1 returns din_a.
- Port B reads the same address port A writes in that cycle: WR_MODE 0 returns the old word; WR_MODE 1 returns the port A din (or the clear write data during a clear).
- Both ports may read the same address in the same cycle. Both get identical data.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_start: counter <= 0, clr_busy <= 1.
  - CLEAR: writes mem[counter] <= CLR_VAL each cycle, then counter++. After writing entry DEPTH-1 -> DONE.
  - DONE: clr_done = 1 for one cycle, clr_busy <= 0, -> IDLE.
  - clr_busy is high for exactly DEPTH cycles. Total start-to-done is DEPTH+1 cycles.
- During CLEAR/DONE, we_a is ignored and the write is dropped with no queuing. Reads on both ports remain legal and return the current array contents, which may be partially cleared. Collision rules apply against the clear write.
- clr_start while busy: ignored. clr_start in the same cycle as we_a in IDLE: the user write is performed and the clear starts the next cycle.
- Reset mid-clear: FSM returns to IDLE, no clr_done is issued, and the memory stays partially cleared.
- Counter width is AW+1 so the DEPTH-1 terminal compare does not wrap.
- Addresses are always in range (DEPTH = 2**AW). There are no error outputs.

Test Plan:
- Basic R/W, OUT_REG=0: write 47'h1234 to addr 5; next cycle re_a and re_b at addr 5 -> both douts = 47'h1234, vld high 1 cycle later; with OUT_REG=1, 2 cycles later.
- Collision: mem[7] = 47'hA, then same cycle we_a with 47'hB to 7 and re_b at 7 -> WR_MODE 0: dout_b = 47'hA; WR_MODE 1: dout_b = 47'hB; subsequent read returns 47'hB.
- Full clear, AW=4: fill all 16 entries with non-zero data, pulse clr_start -> clr_busy high exactly 16 cycles, clr_done at cycle 17, all entries read CLR_VAL.
- Write blocked during clear: we_a to addr 3 with 47'h55 at clear cycle 2 -> after done, mem[3] = CLR_VAL; a second clr_start mid-clear leaves clr_busy length unchanged.
- Reset mid-clear, AW=4: assert rst at clear cycle 8 -> clr_busy = 0, no clr_done, entries 0..7 = CLR_VAL, entries 8..15 keep old data, vld/dout = 0.
- Read-hold: re_a deasserted after a read -> dout_a holds the value, vld_a = 0.
